spi_reg_target: RTL and testbench



---
 rtl/spi_reg_target.sv | 179 +++++++++++++++++
 tb/tb_spi_reg_target.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_target.sv
// spi_reg_target: oversampled SPI mode-0 target bridging host frames onto a 32-bit register bus.
package spi_reg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module spi_reg_target #(
    parameter int unsigned SyncStages = 2,
    parameter logic [31:0] ErrVal     = 32'hBADCAB1E,
    parameter type         reg_req_t  = spi_reg_pkg::reg_req_t,
    parameter type         reg_rsp_t  = spi_reg_pkg::reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     spi_sck_i,
    input  logic     spi_csb_i,
    input  logic     spi_sd_i,
    output logic     spi_sd_o,
    output logic     spi_sd_en_o,
    output reg_req_t reg_req_o,
    input  reg_rsp_t reg_rsp_i,
    output logic     busy_o,
    output logic     drop_o
);
    localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, WDATA = 3'd3;
    localparam logic [2:0] DUMMY = 3'd4, RDATA = 3'd5, IGNORE = 3'd6;
    logic [SyncStages-1:0] sck_sync_q, csb_sync_q, sd_sync_q;
    logic        sck_prev_q, csb_prev_q, sck_s, csb_s, sd_s;
    logic        sck_rise, sck_fall, csb_rise, csb_fall, byte_done, word_done;
    logic [31:0] shift_in;
    logic [2:0]  state_q, state_d, bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d, addr_q, addr_d, tx_q, tx_d;
    logic        wmode_q, wmode_d, drop_q, drop_d;
    logic        wbuf_full_q, wbuf_full_d;
    logic [31:0] wbuf_addr_q, wbuf_addr_d, wbuf_data_q, wbuf_data_d;
    logic        rd_want_q, rd_want_d, rd_out_q, rd_out_d, rdat_ok_q, rdat_ok_d, rdat_err_q, rdat_err_d;
    logic [31:0] rd_addr_q, rd_addr_d, rdat_q, rdat_d;
    logic        req_valid_q, req_valid_d, req_write_q, req_write_d;
    logic [31:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;

    assign sck_s     = sck_sync_q[SyncStages-1];
    assign csb_s     = csb_sync_q[SyncStages-1];
    assign sd_s      = sd_sync_q[SyncStages-1];
    assign sck_rise  = sck_s & ~sck_prev_q & ~csb_s;
    assign sck_fall  = ~sck_s & sck_prev_q & ~csb_s;
    assign csb_fall  = csb_prev_q & ~csb_s;
    assign csb_rise  = ~csb_prev_q & csb_s;
    assign shift_in  = {shift_q[30:0], sd_s};
    assign byte_done = sck_rise & (bit_cnt_q == 3'd7);
    assign word_done = byte_done & (byte_cnt_q == 2'd3);

    always_comb begin
        state_d = state_q; bit_cnt_d = bit_cnt_q; byte_cnt_d = byte_cnt_q; shift_d = shift_q;
        addr_d = addr_q; tx_d = tx_q; wmode_d = wmode_q; drop_d = 1'b0;
        wbuf_full_d = wbuf_full_q; wbuf_addr_d = wbuf_addr_q; wbuf_data_d = wbuf_data_q;
        rd_want_d = rd_want_q; rd_out_d = rd_out_q; rd_addr_d = rd_addr_q;
        rdat_ok_d = rdat_ok_q; rdat_err_d = rdat_err_q; rdat_d = rdat_q;
        req_valid_d = req_valid_q; req_write_d = req_write_q;
        req_addr_d = req_addr_q; req_wdata_d = req_wdata_q;
        // Bus side: complete, else issue a buffered write ahead of any pending read
        if (req_valid_q && reg_rsp_i.ready) begin
            req_valid_d = 1'b0;
            if (rd_out_q) begin
                rd_out_d = 1'b0; rdat_ok_d = 1'b1;
                rdat_d = reg_rsp_i.rdata; rdat_err_d = reg_rsp_i.error;
            end
        end else if (!req_valid_q && wbuf_full_q) begin
            req_valid_d = 1'b1; req_write_d = 1'b1; wbuf_full_d = 1'b0;
            req_addr_d = wbuf_addr_q; req_wdata_d = wbuf_data_q;
        end else if (!req_valid_q && rd_want_q) begin
            req_valid_d = 1'b1; req_write_d = 1'b0; rd_want_d = 1'b0; rd_out_d = 1'b1;
            req_addr_d = rd_addr_q; req_wdata_d = '0;
        end
        if (csb_rise) begin
            state_d = IDLE; tx_d = '0; rd_want_d = 1'b0; rd_out_d = 1'b0; rdat_ok_d = 1'b0;
        end else if (csb_fall) begin
            state_d = CMD; bit_cnt_d = '0; byte_cnt_d = '0; shift_d = '0; tx_d = '0;
        end else begin
            if (sck_rise) begin
                shift_d = shift_in;
                bit_cnt_d = bit_cnt_q + 3'd1;
                byte_cnt_d = byte_done ? byte_cnt_q + 2'd1 : byte_cnt_q;
            end
            if (byte_done) begin
                case (state_q)
                    CMD: begin
                        byte_cnt_d = '0;
                        wmode_d = shift_in[7:0] == 8'h02;
                        state_d = (shift_in[7:0] == 8'h02 || shift_in[7:0] == 8'h03) ? ADDR : IGNORE;
                    end
                    ADDR: if (word_done) begin
                        addr_d = shift_in;
                        state_d = wmode_q ? WDATA : DUMMY;
                        rd_want_d = !wmode_q;
                        rd_addr_d = wmode_q ? rd_addr_q : shift_in;
                    end
                    WDATA: if (word_done) begin
                        addr_d = addr_q + 32'd4;
                        drop_d = wbuf_full_d;
                        if (!wbuf_full_d) begin
                            wbuf_full_d = 1'b1; wbuf_addr_d = addr_q; wbuf_data_d = shift_in;
                        end
                    end
                    DUMMY: begin
                        byte_cnt_d = '0;
                        state_d = RDATA;
                    end
                    default: ;
                endcase
            end
            // First fall of a word: load what arrived (or ErrVal) and prefetch the next address
            if (sck_fall && state_q == RDATA) begin
                if (bit_cnt_q == 3'd0 && byte_cnt_q == 2'd0) begin
                    tx_d = (rdat_ok_q && !rdat_err_q) ? rdat_q : ErrVal;
                    rdat_ok_d = 1'b0; rd_out_d = 1'b0; rd_want_d = 1'b1;
                    rd_addr_d = addr_q + 32'd4; addr_d = addr_q + 32'd4;
                end else begin
                    tx_d = {tx_q[30:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q <= '0; csb_sync_q <= '1; sd_sync_q <= '0;
            sck_prev_q <= 1'b0; csb_prev_q <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
            csb_sync_q <= {csb_sync_q[SyncStages-2:0], spi_csb_i};
            sd_sync_q  <= {sd_sync_q[SyncStages-2:0], spi_sd_i};
            sck_prev_q <= sck_s; csb_prev_q <= csb_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE; bit_cnt_q <= '0; byte_cnt_q <= '0; shift_q <= '0;
            addr_q <= '0; tx_q <= '0; wmode_q <= 1'b0; drop_q <= 1'b0;
            wbuf_full_q <= 1'b0; wbuf_addr_q <= '0; wbuf_data_q <= '0;
            rd_want_q <= 1'b0; rd_out_q <= 1'b0; rd_addr_q <= '0;
            rdat_ok_q <= 1'b0; rdat_err_q <= 1'b0; rdat_q <= '0;
            req_valid_q <= 1'b0; req_write_q <= 1'b0; req_addr_q <= '0; req_wdata_q <= '0;
        end else begin
            state_q <= state_d; bit_cnt_q <= bit_cnt_d; byte_cnt_q <= byte_cnt_d; shift_q <= shift_d;
            addr_q <= addr_d; tx_q <= tx_d; wmode_q <= wmode_d; drop_q <= drop_d;
            wbuf_full_q <= wbuf_full_d; wbuf_addr_q <= wbuf_addr_d; wbuf_data_q <= wbuf_data_d;
            rd_want_q <= rd_want_d; rd_out_q <= rd_out_d; rd_addr_q <= rd_addr_d;
            rdat_ok_q <= rdat_ok_d; rdat_err_q <= rdat_err_d; rdat_q <= rdat_d;
            req_valid_q <= req_valid_d; req_write_q <= req_write_d;
            req_addr_q <= req_addr_d; req_wdata_q <= req_wdata_d;
        end
    end

    always_comb begin
        reg_req_o = '0;
        reg_req_o.addr = req_addr_q;
        reg_req_o.write = req_write_q;
        reg_req_o.wdata = req_wdata_q;
        reg_req_o.wstrb = {4{req_valid_q}};
        reg_req_o.valid = req_valid_q;
    end

    assign spi_sd_o    = tx_q[31];
    assign spi_sd_en_o = ~csb_s & (state_q == RDATA);
    assign busy_o      = req_valid_q;
    assign drop_o      = drop_q;
endmodule

// File: tb/tb_spi_reg_target.sv
// tb_spi_reg_target: directed frame table plus hand-written corner sequences for spi_reg_target.
module tb_spi_reg_target;
    import spi_reg_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, csb = 1'b1, sd = 1'b0;
    logic sd_o, sd_en, busy, drop;
    logic rdy = 1'b1, err_on = 1'b0;
    logic [31:0] err_addr = '0;
    reg_req_t req;
    reg_rsp_t rsp;
    int n_chk = 0, n_fail = 0, drop_cnt = 0, en_cnt = 0;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;
    txn_t log_q[$];
    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;
    vec_t vecs[5];

    spi_reg_target dut (
        .clk_i(clk), .rst_ni(rst_n), .spi_sck_i(sck), .spi_csb_i(csb), .spi_sd_i(sd),
        .spi_sd_o(sd_o), .spi_sd_en_o(sd_en), .reg_req_o(req), .reg_rsp_i(rsp),
        .busy_o(busy), .drop_o(drop)
    );

    always #5 clk = ~clk;

    always_comb begin
        rsp.rdata = req.addr ^ 32'hA5A5A5A5;
        rsp.error = err_on && (req.addr == err_addr);
        rsp.ready = rdy;
    end

    always @(posedge clk) begin
        if (req.valid && rsp.ready) log_q.push_back({req.addr, req.write, req.wdata, req.wstrb});
        if (drop) drop_cnt++;
        if (sd_en) en_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sd = b;
        repeat (4) @(negedge clk);
        r = sd_o;
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic byte_xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic word_xfer(input logic [31:0] tx, output logic [31:0] rx);
        logic r;
        for (int i = 31; i >= 0; i--) begin
            bit_xfer(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_low();
        csb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        csb = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr);
        logic [7:0] b;
        logic [31:0] w;
        cs_low();
        byte_xfer(cmd, b);
        word_xfer(addr, w);
    endtask

    task automatic write_frame(input logic [31:0] addr, input logic [31:0] data);
        int n0, d0;
        logic [31:0] w;
        n0 = log_q.size();
        d0 = drop_cnt;
        send_hdr(8'h02, addr);
        word_xfer(data, w);
        cs_high();
        repeat (4) @(negedge clk);
        chk("wr count", 32'(log_q.size() - n0), 32'd1);
        chk("wr drop", 32'(drop_cnt - d0), 32'd0);
        if (log_q.size() > n0) begin
            chk("wr addr", log_q[n0].addr, addr);
            chk("wr write", 32'(log_q[n0].write), 32'd1);
            chk("wr wdata", log_q[n0].wdata, data);
            chk("wr wstrb", 32'(log_q[n0].wstrb), 32'hF);
        end
    endtask

    task automatic read_frame(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp0, input logic [31:0] exp1);
        int n0, e0;
        logic [7:0] b;
        logic [31:0] w0, w1;
        n0 = log_q.size();
        e0 = en_cnt;
        send_hdr(8'h03, addr);
        byte_xfer(8'h00, b);
        word_xfer(32'h0, w0);
        word_xfer(32'h0, w1);
        cs_high();
        chk({tag, " word0"}, w0, exp0);
        chk({tag, " word1"}, w1, exp1);
        chk({tag, " miso enabled"}, 32'(en_cnt > e0), 32'd1);
        chk({tag, " read count"}, 32'(log_q.size() >= n0 + 3), 32'd1);
        if (log_q.size() >= n0 + 3) begin
            chk({tag, " addr0"}, log_q[n0].addr, addr);
            chk({tag, " addr1"}, log_q[n0+1].addr, addr + 32'd4);
            chk({tag, " addr2"}, log_q[n0+2].addr, addr + 32'd8);
            chk({tag, " is read"}, 32'(log_q[n0].write), 32'd0);
        end
    endtask

    initial begin
        int n0, d0, e0;
        logic [7:0] b;
        logic [31:0] w0, w1;
        logic r;
        vecs[0] = '{1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0200, 32'h0, 32'hA5A5A7A5, 32'hA5A5A7A1};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0, 32'h5A5A5A59, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 32'h0, 32'h0};

        repeat (3) @(negedge clk);
        chk("reset sd_o", 32'(sd_o), 32'd0);
        chk("reset sd_en", 32'(sd_en), 32'd0);
        chk("reset valid", 32'(req.valid), 32'd0);
        chk("reset addr", req.addr, 32'd0);
        chk("reset wdata", req.wdata, 32'd0);
        chk("reset wstrb", 32'(req.wstrb), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset drop", 32'(drop), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].rd) read_frame("rd vec", vecs[i].addr, vecs[i].exp0, vecs[i].exp1);
            else write_frame(vecs[i].addr, vecs[i].data);
        end

        err_on = 1'b1;
        err_addr = 32'h300;
        read_frame("rd err", 32'h300, 32'hBADCAB1E, 32'hA5A5A6A1);
        err_on = 1'b0;

        // Underrun: the 0x400 response lands mid-word and must not reach the host
        rdy = 1'b0;
        n0 = log_q.size();
        send_hdr(8'h03, 32'h400);
        byte_xfer(8'h00, b);
        fork
            begin
                repeat (200) @(posedge clk);
                rdy = 1'b1;
            end
        join_none
        word_xfer(32'h0, w0);
        word_xfer(32'h0, w1);
        cs_high();
        chk("underrun word0", w0, 32'hBADCAB1E);
        chk("underrun word1", w1, 32'hA5A5A1A1);
        chk("underrun count", 32'(log_q.size() >= n0 + 2), 32'd1);
        if (log_q.size() >= n0 + 2) begin
            chk("underrun late addr", log_q[n0].addr, 32'h400);
            chk("underrun next addr", log_q[n0+1].addr, 32'h404);
        end

        // Write backpressure: third word finds the buffer full
        rdy = 1'b0;
        n0 = log_q.size();
        d0 = drop_cnt;
        send_hdr(8'h02, 32'h0);
        word_xfer(32'h1111_1111, w0);
        word_xfer(32'h2222_2222, w0);
        word_xfer(32'h3333_3333, w0);
        cs_high();
        chk("bp drop pulses", 32'(drop_cnt - d0), 32'd1);
        chk("bp busy held", 32'(busy), 32'd1);
        chk("bp addr held", req.addr, 32'h0);
        rdy = 1'b1;
        repeat (10) @(negedge clk);
        chk("bp write count", 32'(log_q.size() - n0), 32'd2);
        if (log_q.size() >= n0 + 2) begin
            chk("bp w0 addr", log_q[n0].addr, 32'h0);
            chk("bp w0 data", log_q[n0].wdata, 32'h1111_1111);
            chk("bp w1 addr", log_q[n0+1].addr, 32'h4);
            chk("bp w1 data", log_q[n0+1].wdata, 32'h2222_2222);
        end
        chk("bp busy released", 32'(busy), 32'd0);

        // Abort after 20 data bits
        n0 = log_q.size();
        send_hdr(8'h02, 32'h40);
        for (int i = 0; i < 20; i++) bit_xfer(1'b1, r);
        cs_high();
        repeat (6) @(negedge clk);
        chk("abort no request", 32'(log_q.size() - n0), 32'd0);

        // Unknown command
        n0 = log_q.size();
        e0 = en_cnt;
        cs_low();
        byte_xfer(8'hFF, b);
        byte_xfer(8'h00, b);
        byte_xfer(8'h00, b);
        cs_high();
        repeat (6) @(negedge clk);
        chk("unknown cmd miso off", 32'(en_cnt - e0), 32'd0);
        chk("unknown cmd no request", 32'(log_q.size() - n0), 32'd0);

        // Asynchronous reset mid-RDATA with a read outstanding
        rdy = 1'b0;
        send_hdr(8'h03, 32'h500);
        byte_xfer(8'h00, b);
        for (int i = 0; i < 4; i++) bit_xfer(1'b0, r);
        chk("pre-reset busy", 32'(busy), 32'd1);
        chk("pre-reset sd_en", 32'(sd_en), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(req.valid), 32'd0);
        chk("async reset sd_en", 32'(sd_en), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        csb = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        repeat (4) @(negedge clk);
        write_frame(32'h10, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
